hilo_unit: RTL
==============

// Module: hilo_unit
// PURPOSE
//  Consumer end of the ALU result interface: captures 64-bit MPY/DIV results into the HI/LO registers and latches N/Z/V/C status.
//  Models multiply/divide latency with a busy interlock.
//  Serves mfhi/mflo reads and mthi/mtlo writes from the control unit, stalling them while a MPY/DIV is in flight.
//  Sits between alu_32 outputs and the datapath writeback / control unit.
// PARAMETERS
//  MUL_LAT   4    cycles from MPY issue to HI/LO commit (>=1)
//  DIV_LAT   32   cycles from DIV issue to HI/LO commit (>=1)
//  CNT_W     6    latency counter width; must hold max(MUL_LAT,DIV_LAT)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  alu_valid  in   1   ALU result valid this cycle (op issue)
//  FS         in   5   function select of the issued op
//  Y_hi,Y_lo  in   32  ALU outputs
//  N,Z,V,C    in   1   ALU flags
//  T_zero     in   1   divisor==0 (present only with HILO_DIVZERO_TRAP_EN)
//  rd_req     in   1   mfhi/mflo request
//  wr_req     in   1   mthi/mtlo request
//  sel_hi     in   1   1=HI, 0=LO for rd_req/wr_req
//  wr_data    in   32  mthi/mtlo data
//  stall      out  1   combinational: request this cycle not accepted
//  busy       out  1   MPY/DIV in flight
//  rd_valid   out  1   rd_data valid (one-cycle pulse)
//  rd_data    out  32  read data
//  HI,LO      out  32  architectural HI/LO
//  flags      out  4   registered {N,Z,V,C}
//  divz_trap  out  1   one-cycle pulse (present only with HILO_DIVZERO_TRAP_EN)
// BEHAVIOUR
//  Reset: state IDLE, HI=LO=0, flags=0, busy=0, rd_valid=0, rd_data=0, counter=0, shadow=0, divz_trap=0; in-flight op discarded.
//  FSM: IDLE -> MUL_BUSY on accepted alu_valid&FS==5'h1E; IDLE -> DIV_BUSY on FS==5'h1F.
//  BUSY -> IDLE when counter==0 (commit cycle).
//  Issue: {Y_hi,Y_lo} copied to shadow; counter loaded with LAT-1; busy=1 from next cycle.
//  HI/LO <= shadow at the edge ending the commit cycle. Total issue-to-visible latency is LAT cycles.
//  Flags: every accepted alu_valid (any FS) writes flags next cycle, including MPY/DIV at issue. The commit never writes flags.
//  alu_valid with FS 1E/1F while busy -> stall=1, not accepted. Other FS while busy -> accepted, flags only.
//  rd_req while busy and not commit cycle -> stall=1.
//  rd_req accepted -> rd_valid=1, rd_data=selected reg next cycle. A read in the commit cycle returns the committed shadow value (bypass).
//  wr_req while busy -> stall=1. wr_req accepted -> target reg <= wr_data next cycle.
//  Simultaneous rd_req and wr_req on the same reg, both accepted: rd_data returns the old value.
//  Priority at the same edge: commit < wr_req. MPY/DIV issue cannot coincide with wr_req: the control unit guarantees it; assert in sim.
//  MPY/DIV issue in the commit cycle -> stall=1 (re-issue after IDLE).
// CONFIGURATION
//  HILO_DIVZERO_TRAP_EN defined:
//    DIV issued with T_zero=1 still occupies DIV_LAT cycles.
//    At commit, HI/LO are left unchanged and divz_trap pulses 1 cycle.
//  HILO_DIVZERO_TRAP_EN undefined:
//    T_zero and divz_trap ports are absent.
//    DIV always commits Y_div unchanged.
// STRUCTURE
//  Package hilo_pkg:
//    FS_MUL=5'h1E, FS_DIV=5'h1F.
//    State encoding IDLE/MUL_BUSY/DIV_BUSY (2 bits).
//    Flag index constants F_N=3, F_Z=2, F_V=1, F_C=0.
//  Sub-module hilo_lat_counter: load/decrement counter with zero flag, width CNT_W.
// TESTING
//  MPY issue with Y_hi=32'h1, Y_lo=32'hFFFF_FFFE, MUL_LAT=4 -> busy cycles 1-4; HI=1, LO=FFFF_FFFE visible at cycle 4.
//  mflo requested at cycle 1 of that MPY -> stall through cycle 3; accepted at cycle 4; rd_data=FFFF_FFFE at cycle 5.
//  ADD (FS 5'h02) issued during DIV busy with N=1 -> accepted, stall=0, flags=4'b1000; HI/LO unchanged until DIV commit.
//  mthi 32'hDEAD_BEEF while idle, then mfhi next cycle -> rd_data=DEAD_BEEF, rd_valid 1 cycle.
//  Reset asserted at DIV cycle 10 -> next cycle busy=0, HI=LO=0, no later commit.
//  HILO_DIVZERO_TRAP_EN, DIV with T_zero=1, HI=5 preset -> divz_trap pulses at cycle DIV_LAT; HI stays 5.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants for the HI/LO unit (op codes, FSM encoding, flag bit positions).
package hilo_pkg;

    localparam logic [4:0] FS_MUL = 5'h1E;
    localparam logic [4:0] FS_DIV = 5'h1F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } hilo_state_t;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_V = 1;
    localparam int F_C = 0;

    // True for the long-latency ops that own HI/LO until they commit
    function automatic logic is_muldiv(input logic [4:0] fs);
        return (fs == FS_MUL) || (fs == FS_DIV);
    endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable down-counter that stops at zero and flags it.
module hilo_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load wins over decrement; decrement saturates at zero
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with MPY/DIV latency interlock, flag latch
// and mfhi/mflo/mthi/mtlo service. Optional divide-by-zero trap is enabled
// by defining HILO_DIVZERO_TRAP_EN (adds T_zero input and divz_trap output).
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  FS,
    input  logic [31:0] Y_hi,
    input  logic [31:0] Y_lo,
    input  logic        N,
    input  logic        Z,
    input  logic        V,
    input  logic        C,
`ifdef HILO_DIVZERO_TRAP_EN
    input  logic        T_zero,
`endif
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        sel_hi,
    input  logic [31:0] wr_data,
    output logic        stall,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] HI,
    output logic [31:0] LO,
`ifdef HILO_DIVZERO_TRAP_EN
    output logic        divz_trap,
`endif
    output logic [3:0]  flags
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    hilo_state_t      r_state;
    logic [63:0]      r_shadow;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [3:0]       r_flags;
    logic             r_rd_valid;
    logic [31:0]      r_rd_data;

    logic             w_busy;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt;
    logic             w_commit;
    logic             w_commit_wr;
    logic             w_muldiv;
    logic             w_stall_alu;
    logic             w_stall_rd;
    logic             w_stall_wr;
    logic             w_alu_acc;
    logic             w_issue;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [CNT_W-1:0] w_load_val;
    logic [31:0]      w_hi_now;
    logic [31:0]      w_lo_now;

    assign w_busy   = (r_state != IDLE);
    assign w_commit = w_busy && w_cnt_zero;
    assign w_muldiv = alu_valid && is_muldiv(FS);

    // A new MPY/DIV is refused for the whole busy window, commit cycle
    // included; reads only need to wait until the result is known.
    assign w_stall_alu = w_muldiv && w_busy;
    assign w_stall_rd  = rd_req && w_busy && !w_commit;
    assign w_stall_wr  = wr_req && w_busy;
    assign stall       = w_stall_alu || w_stall_rd || w_stall_wr;

    assign w_alu_acc  = alu_valid && !w_stall_alu;
    assign w_issue    = w_muldiv && !w_busy;
    assign w_rd_acc   = rd_req && !w_stall_rd;
    assign w_wr_acc   = wr_req && !w_stall_wr;
    assign w_load_val = (FS == FS_MUL) ? MUL_CNT : DIV_CNT;

`ifdef HILO_DIVZERO_TRAP_EN
    logic r_shadow_tz;
    logic r_divz_trap;

    // A trapped divide runs its full latency but never lands in HI/LO
    assign w_commit_wr = w_commit && !((r_state == DIV_BUSY) && r_shadow_tz);

    // Trap pulse follows the commit cycle of a zero-divisor DIV
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_tz <= 1'b0;
            r_divz_trap <= 1'b0;
        end else begin
            if (w_issue)
                r_shadow_tz <= (FS == FS_DIV) && T_zero;
            r_divz_trap <= w_commit && (r_state == DIV_BUSY) && r_shadow_tz;
        end
    end

    assign divz_trap = r_divz_trap;
`else
    assign w_commit_wr = w_commit;
`endif

    // Values a read sees this cycle: the committing result is bypassed
    assign w_hi_now = w_commit_wr ? r_shadow[63:32] : r_hi;
    assign w_lo_now = w_commit_wr ? r_shadow[31:0]  : r_lo;

    hilo_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_issue),
        .i_load_val (w_load_val),
        .i_dec      (w_busy),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // Busy FSM: capture result into shadow at issue, return to IDLE on commit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shadow <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_shadow <= {Y_hi, Y_lo};
                        r_state  <= (FS == FS_MUL) ? MUL_BUSY : DIV_BUSY;
                    end
                end
                MUL_BUSY, DIV_BUSY: begin
                    if (w_commit)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // HI/LO update: commit first, an accepted mthi/mtlo overrides it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_commit_wr) begin
                r_hi <= r_shadow[63:32];
                r_lo <= r_shadow[31:0];
            end
            if (w_wr_acc) begin
                if (sel_hi)
                    r_hi <= wr_data;
                else
                    r_lo <= wr_data;
            end
        end
    end

    // Flag latch on every accepted ALU op; commit leaves flags alone
    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= '0;
        else if (w_alu_acc) begin
            r_flags[F_N] <= N;
            r_flags[F_Z] <= Z;
            r_flags[F_V] <= V;
            r_flags[F_C] <= C;
        end
    end

    // mfhi/mflo response: one-cycle valid, data holds until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc)
                r_rd_data <= sel_hi ? w_hi_now : w_lo_now;
        end
    end

    // Control unit never issues MPY/DIV alongside an accepted mthi/mtlo
    a_no_issue_with_wr : assert property (@(posedge clk) disable iff (reset)
        !(w_issue && w_wr_acc));

    assign busy     = w_busy;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign flags    = r_flags;

endmodule
